// File: rtl/my_logic_pipe.sv
// my_logic_pipe: two-stage pipelined bitwise logic unit with valid/ready handshakes.
//
// Stage 1 captures the operands and function code. Stage 2 holds the result
// together with its zero and parity flags. An internal XOR accumulator serves
// function code 7.
//
// Ports:
//   clk        clock, rising-edge active
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand beat this cycle
//   a, b       W-bit operands
//   f          3-bit function code
//   out_valid  result beat valid
//   out_ready  consumer accepts the result this cycle
//   out        W-bit result
//   zero       out == 0, registered with out
//   parity     XOR-reduction of out, registered with out
module my_logic_pipe #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   f,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out,
   output logic         zero,
   output logic         parity
);

   logic         s1_v;
   logic [W-1:0] s1_a;
   logic [W-1:0] s1_b;
   logic [2:0]   s1_f;
   logic         s2_v;
   logic [W-1:0] acc;

   logic         s2_load;
   logic         accept;
   logic [W-1:0] acc_next;
   logic [W-1:0] res;

   // Handshake control. in_ready depends on out_ready in the same cycle, so a
   // full pipeline frees up as soon as the consumer takes the result.
   always_comb begin
      s2_load  = s1_v & (~s2_v | out_ready);
      in_ready = ~s1_v | s2_load;
      accept   = in_valid & in_ready;
   end

   always_comb begin
      acc_next = acc ^ s1_a;
   end

   always_comb begin
      res = '0;
      case (s1_f)
         3'd0:    res = s1_a & s1_b;
         3'd1:    res = s1_a | s1_b;
         3'd2:    res = s1_a ^ s1_b;
         3'd3:    res = ~s1_a;
         3'd4:    res = ~(s1_a & s1_b);
         3'd5:    res = ~(s1_a | s1_b);
         3'd6:    res = ~(s1_a ^ s1_b);
         3'd7:    res = acc_next;
         default: res = '0;
      endcase
   end

   // Stage 1. When in_ready is high the slot is either empty or draining, so
   // its valid bit simply follows in_valid; otherwise it holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v <= 1'b0;
         s1_a <= '0;
         s1_b <= '0;
         s1_f <= 3'd0;
      end else begin
         if (in_ready) begin
            s1_v <= in_valid;
         end
         if (accept) begin
            s1_a <= a;
            s1_b <= b;
            s1_f <= f;
         end
      end
   end

   // Stage 2 holds its result while stalled; it empties only when consumed
   // without a replacement arriving.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v   <= 1'b0;
         out    <= '0;
         zero   <= 1'b1;
         parity <= 1'b0;
      end else if (s2_load) begin
         s2_v   <= 1'b1;
         out    <= res;
         zero   <= ~|res;
         parity <= ^res;
      end else if (out_ready) begin
         s2_v <= 1'b0;
      end
   end

   // The accumulator advances only on the s1->s2 transfer, so a beat stalled in
   // stage 1 is counted exactly once and back-to-back f=7 beats chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (s2_load && (s1_f == 3'd7)) begin
         acc <= acc_next;
      end
   end

   always_comb begin
      out_valid = s2_v;
   end

endmodule

// File: tb/tb_my_logic_pipe.sv
// Scoreboard bench for my_logic_pipe: W=4 main instance with random stalls,
// plus W=16 and W=1 instances exercised with fixed sequences.
module tb_my_logic_pipe;

   localparam int W = 4;
   typedef logic [W+1:0] exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   f;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         zero;
   logic         parity;

   // W=16 instance
   logic        in_valid16;
   logic        in_ready16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic [2:0]  f16;
   logic        out_valid16;
   logic [15:0] out16;
   logic        zero16;
   logic        parity16;

   // W=1 instance
   logic        in_valid1;
   logic        in_ready1;
   logic [0:0]  a1;
   logic [0:0]  b1;
   logic [2:0]  f1;
   logic        out_valid1;
   logic [0:0]  out1;
   logic        zero1;
   logic        parity1;

   int           checks = 0;
   int           errors = 0;
   int           pops = 0;
   exp_t         sbq[$];
   logic [W-1:0] macc;

   always #5 clk = ~clk;

   my_logic_pipe #(.W(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .f         (f),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero      (zero),
      .parity    (parity)
   );

   my_logic_pipe #(.W(16)) u_dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .a         (a16),
      .b         (b16),
      .f         (f16),
      .out_valid (out_valid16),
      .out_ready (1'b1),
      .out       (out16),
      .zero      (zero16),
      .parity    (parity16)
   );

   my_logic_pipe #(.W(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .f         (f1),
      .out_valid (out_valid1),
      .out_ready (1'b1),
      .out       (out1),
      .zero      (zero1),
      .parity    (parity1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the function table applied to whole words, acc kept in
   // acceptance order. A fixed expectation can override the computed result.
   task automatic push(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [2:0] vf,
                       input bit use_exp, input logic [W-1:0] ev);
      logic [W-1:0] r;
      case (vf)
         3'd0:    r = va & vb;
         3'd1:    r = va | vb;
         3'd2:    r = va ^ vb;
         3'd3:    r = ~va;
         3'd4:    r = ~(va & vb);
         3'd5:    r = ~(va | vb);
         3'd6:    r = ~(va ^ vb);
         default: begin
            macc = macc ^ va;
            r    = macc;
         end
      endcase
      if (use_exp) r = ev;
      sbq.push_back({r, (r == '0), ^r});
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   // with in_valid still high so beats can go back to back.
   task automatic beat(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [2:0] vf,
                       input bit use_exp, input logic [W-1:0] ev);
      int n = 0;
      in_valid = 1'b1;
      a = va;
      b = vb;
      f = vf;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 100) begin
            chk("beat_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
            return;
         end
      end
      push(va, vb, vf, use_exp, ev);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sbq.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain", sbq.size(), 32'd0);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      sbq.delete();
      macc = '0;
      chk("rst_async_out_valid", out_valid, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 32'd0);
      chk("rst_out", out, 32'd0);
      chk("rst_zero", zero, 32'd1);
      chk("rst_parity", parity, 32'd0);
      chk("rst_in_ready", in_ready, 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every consumed result and checks that a
   // stalled result does not change.
   initial begin
      logic       prev_stall;
      logic [W+1:0] prev_vec;
      exp_t       e;
      prev_stall = 1'b0;
      prev_vec   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && out_valid) chk("hold_stable", {zero, parity, out}, prev_vec);
            if (out_valid && out_ready) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_out", 32'd1, 32'd0);
               end else begin
                  e = sbq.pop_front();
                  chk("out", out, e[W+1:2]);
                  chk("zero", zero, e[1]);
                  chk("parity", parity, e[0]);
                  pops++;
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_vec   = {zero, parity, out};
         end
      end
   end

   logic [15:0] t16_a [5] = '{16'h00FF, 16'h5555, 16'h1234, 16'h1234, 16'h00F0};
   logic [15:0] t16_b [5] = '{16'h0000, 16'h0F0F, 16'h0000, 16'h0000, 16'h0000};
   logic [2:0]  t16_f [5] = '{3'd3, 3'd2, 3'd7, 3'd7, 3'd7};
   logic [15:0] t16_e [5] = '{16'hFF00, 16'h5A5A, 16'h1234, 16'h0000, 16'h00F0};
   logic [0:0]  t1_a [5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [0:0]  t1_b [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [2:0]  t1_f [5]  = '{3'd3, 3'd4, 3'd7, 3'd7, 3'd7};
   logic [0:0]  t1_e [5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      int          p0;
      int          accepted;
      int          cyc;
      logic [W-1:0] first_out;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [2:0]   rf;

      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      a          = '0;
      b          = '0;
      f          = 3'd0;
      in_valid16 = 1'b0;
      a16        = '0;
      b16        = '0;
      f16        = 3'd0;
      in_valid1  = 1'b0;
      a1         = '0;
      b1         = '0;
      f1         = 3'd0;
      macc       = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("init_out_valid", out_valid, 32'd0);
      chk("init_in_ready", in_ready, 32'd1);
      chk("init_zero", zero, 32'd1);
      @(posedge clk);
      #1;

      // Reset with two beats in flight; neither may ever appear.
      out_ready = 1'b1;
      beat(4'b1100, 4'b1010, 3'd1, 1'b0, '0);
      beat(4'b0110, 4'b0011, 3'd7, 1'b0, '0);
      p0 = pops;
      do_reset();
      repeat (4) @(posedge clk);
      #1;
      chk("rst_dropped", pops, p0);

      // All fixed functions back to back.
      p0 = pops;
      beat(4'b0101, 4'b0011, 3'd0, 1'b1, 4'b0001);
      beat(4'b0101, 4'b0011, 3'd1, 1'b1, 4'b0111);
      beat(4'b0101, 4'b0011, 3'd2, 1'b1, 4'b0110);
      beat(4'b0101, 4'b0011, 3'd3, 1'b1, 4'b1010);
      beat(4'b0101, 4'b0011, 3'd4, 1'b1, 4'b1110);
      beat(4'b0101, 4'b0011, 3'd5, 1'b1, 4'b1000);
      beat(4'b0101, 4'b0011, 3'd6, 1'b1, 4'b1001);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("throughput", pops - p0, 32'd7);

      // Accumulator, then reset clears it.
      beat(4'b0101, 4'b0000, 3'd7, 1'b1, 4'b0101);
      beat(4'b0101, 4'b0000, 3'd7, 1'b1, 4'b0000);
      beat(4'b0011, 4'b0000, 3'd7, 1'b1, 4'b0011);
      drain();
      do_reset();
      out_ready = 1'b1;
      beat(4'b1000, 4'b0000, 3'd7, 1'b1, 4'b1000);
      drain();

      // Backpressure: only two beats fit, then same-cycle release.
      out_ready = 1'b0;
      beat(4'b1001, 4'b0110, 3'd2, 1'b0, '0);
      beat(4'b0111, 4'b0001, 3'd7, 1'b0, '0);
      first_out = sbq[0][W+1:2];
      in_valid = 1'b1;
      a = 4'b1110;
      b = 4'b0100;
      f = 3'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 32'd0);
         chk("bp_out_valid", out_valid, 32'd1);
         chk("bp_out", out, first_out);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", in_ready, 32'd1);
      push(4'b1110, 4'b0100, 3'd5, 1'b0, '0);
      @(posedge clk);
      #1;
      beat(4'b0010, 4'b1011, 3'd7, 1'b0, '0);
      drain();

      // Random traffic with random stalls on both sides.
      accepted = 0;
      cyc = 0;
      while (accepted < 1000 && cyc < 20000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         ra = W'($urandom);
         rb = W'($urandom);
         rf = 3'($urandom);
         a = ra;
         b = rb;
         f = rf;
         @(negedge clk);
         if (in_valid && in_ready) begin
            push(ra, rb, rf, 1'b0, '0);
            accepted++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("random_accepted", accepted, 32'd1000);
      drain();

      // W=16 and W=1 instances, consumer always ready.
      for (int i = 0; i < 7; i++) begin
         if (i < 5) begin
            in_valid16 = 1'b1;
            a16 = t16_a[i];
            b16 = t16_b[i];
            f16 = t16_f[i];
            in_valid1 = 1'b1;
            a1 = t1_a[i];
            b1 = t1_b[i];
            f1 = t1_f[i];
         end else begin
            in_valid16 = 1'b0;
            in_valid1  = 1'b0;
         end
         @(negedge clk);
         if (i >= 2) begin
            chk("w16_valid", out_valid16, 32'd1);
            chk("w16_out", out16, t16_e[i-2]);
            chk("w16_zero", zero16, (t16_e[i-2] == 16'h0));
            chk("w16_parity", parity16, ^t16_e[i-2]);
            chk("w1_valid", out_valid1, 32'd1);
            chk("w1_out", out1, t1_e[i-2]);
            chk("w1_zero", zero1, (t1_e[i-2] == 1'b0));
            chk("w1_parity", parity1, t1_e[i-2]);
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("w16_idle", out_valid16, 32'd0);
      chk("w1_idle", out_valid1, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/my_logic_pipe.md
# my_logic_pipe

Parametrised, pipelined successor to the team's 4-bit registered logic unit. It accepts two W-bit operands and a 3-bit function code through a valid/ready handshake, and returns the registered result two cycles later with zero and parity flags. It adds four functions to the original four: NAND, NOR, XNOR and an XOR accumulator. It sits between an operand source and a result consumer, and either side may stall.

## Interface
Parameters:
- W, default 4: operand and result width, W ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- f  in  3  function code.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out  out  W  result.
- zero  out  1  out == 0, registered with out.
- parity  out  1  XOR-reduction of out, registered with out.

## Operation
Function codes, applied bitwise on W bits:
- 0: a & b
- 1: a | b
- 2: a ^ b
- 3: ~a (b ignored)
- 4: ~(a & b)
- 5: ~(a | b)
- 6: ~(a ^ b)
- 7: accumulate. acc <= acc ^ a; the result is the new acc value; b is ignored.

Accumulator:
- acc is an internal W-bit register, reset to 0.
- It updates only when an f=7 beat moves from stage 1 to stage 2, exactly once per accepted f=7 beat.

Pipeline:
- Stage 1 (s1) registers a, b and f, with valid bit s1_v.
- Stage 2 (s2) registers out, zero and parity, with valid bit s2_v; out_valid = s2_v.
- Combinational control:
  - s2_load = s1_v & (~s2_v | out_ready)
  - in_ready = ~s1_v | s2_load
- An input beat is accepted when in_valid & in_ready.
- An output beat is consumed when out_valid & out_ready.
- Each stage holds its contents while it cannot advance. out, zero and parity are stable while out_valid=1 and out_ready=0.
- Beats are never dropped, duplicated or reordered.
- Sustained throughput is 1 beat/cycle while out_ready=1.

Reset (asynchronous, active-high):
- s1_v=0, s2_v=0, acc=0, out=0, zero=1, parity=0.
- in_ready=1 from the first cycle after reset; out_valid=0.
- Reset mid-operation discards every in-flight beat and clears acc. The first beat after reset starts from acc=0.

## Timing
- Latency: a beat accepted at rising edge N is presented with out_valid=1 after edge N+1, provided s2 is empty or drains at edge N+1.
- Full pipeline: s1_v=1, s2_v=1 and out_ready=0.
  - in_ready=0, so no acceptance.
  - Release is same-cycle: raising out_ready makes in_ready=1 in that cycle, and a new beat may be accepted on the same edge the result is consumed.
- Empty pipeline: out_valid=0. out, zero and parity hold their last values and are don't-care for the consumer.
- Simultaneous events:
  - Accept into s1, s1→s2 transfer and output consumption can all happen on one edge.
  - Back-to-back f=7 beats chain correctly: the second uses the acc value produced by the first.
- in_valid and the operand inputs may change freely while in_ready=0; nothing is sampled until acceptance.
- f is 3 bits, so every code is defined and there is no illegal-code behaviour.

## Test plan
W=4 unless noted.
1. Reset: assert rst mid-stream with two beats in flight, then release.
   - Required: out_valid=0, out=0000, zero=1, parity=0, in_ready=1. The dropped beats never appear.
2. All functions: a=0101, b=0011, f=0..6 back-to-back, out_ready=1.
   - Required, one per cycle from 2 cycles after the first accept: 0001, 0111, 0110, 1010, 1110, 1000, 1001.
   - Parity: 1, 1, 0, 0, 1, 1, 0.
3. Accumulator: f=7 with a=0101, then a=0101, then a=0011.
   - Required out: 0101, 0000 (zero=1), 0011.
   - Then assert rst, release, and send f=7 with a=1000. Required out: 1000.
4. Backpressure: hold out_ready=0 and stream 4 beats.
   - Required: exactly 2 accepted, then in_ready=0; out stays stable at the first result.
   - Then raise out_ready=1. Required: all 4 results in order, 1 per cycle, and a same-cycle accept while full.
5. Random stall: random in_valid and out_ready over 1000 beats with random f, a and b, checked against a scoreboard model including acc.
   - Required: exact in-order match and no loss or duplication.
6. Width: repeat scenarios 2–3 with W=1 and W=16.
   - Required, W=16, f=3, a=0x00FF: out=0xFF00, parity=0.
